// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: in-flight rd scoreboard, stall/bubble/flush, operand forwarding, multi-cycle EX handshake.
// Optional perf counters enabled with `define HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic [RA_W-1:0]  i_id_rs1_addr,
    input  logic [RA_W-1:0]  i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [RA_W-1:0]  i_id_rd_addr,
    input  logic             i_id_rd_wen,
    input  logic             i_id_is_load,
    input  logic             i_id_is_mc,
    input  logic             i_ex_branch_taken,
    input  logic             i_mc_done,
    output logic             o_pc_stall,
    output logic             o_if_id_stall,
    output logic             o_if_id_flush,
    output logic             o_id_ex_bubble,
    output logic             o_ex_hold,
    output logic             o_mc_start,
    output logic [1:0]       o_fwd_rs1_sel,
    output logic [1:0]       o_fwd_rs2_sel,
    output logic [CNT_W-1:0] o_perf_stall_cycles,
    output logic [CNT_W-1:0] o_perf_flush_count
);

    typedef enum logic [1:0] {S_RUN, S_LOAD_STALL, S_MC_WAIT} state_t;

    typedef struct packed {
        logic            valid;
        logic            wen;
        logic            load;
        logic [RA_W-1:0] rd;
    } ex_ent_t;

    // WB producers are served by regfile write-through, and nothing past EX needs the load flag,
    // so only EX and MEM entries are kept.
    typedef struct packed {
        logic            valid;
        logic            wen;
        logic [RA_W-1:0] rd;
    } mem_ent_t;

    state_t   r_state, w_state_nxt;
    ex_ent_t  r_ex;
    mem_ent_t r_mem;
    logic [1:0] r_fwd1, r_fwd2;

    logic w_m1_ex, w_m2_ex, w_m1_mem, w_m2_mem, w_load_use, w_issue;
    logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_bubble, w_ex_hold, w_mc_start;
    logic [1:0] w_fwd1, w_fwd2;

    function automatic logic f_match(input logic used, input logic [RA_W-1:0] rs,
                                     input logic v, input logic wen, input logic [RA_W-1:0] rd);
        return used && v && wen && (rs == rd) && (rd != '0);
    endfunction

    assign w_m1_ex    = f_match(i_id_rs1_used, i_id_rs1_addr, r_ex.valid, r_ex.wen, r_ex.rd);
    assign w_m2_ex    = f_match(i_id_rs2_used, i_id_rs2_addr, r_ex.valid, r_ex.wen, r_ex.rd);
    assign w_m1_mem   = f_match(i_id_rs1_used, i_id_rs1_addr, r_mem.valid, r_mem.wen, r_mem.rd);
    assign w_m2_mem   = f_match(i_id_rs2_used, i_id_rs2_addr, r_mem.valid, r_mem.wen, r_mem.rd);
    assign w_load_use = i_id_valid && r_ex.load && (w_m1_ex || w_m2_ex);
    assign w_fwd1     = w_m1_ex ? 2'b01 : (w_m1_mem ? 2'b10 : 2'b00);
    assign w_fwd2     = w_m2_ex ? 2'b01 : (w_m2_mem ? 2'b10 : 2'b00);

    // LOAD_STALL and the mc_done cycle of MC_WAIT evaluate ID exactly like RUN;
    // a branch cannot be resolving in EX while the multi-cycle op occupies it.
    always_comb begin
        w_state_nxt    = S_RUN;
        w_issue        = 1'b0;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_ex_hold      = 1'b0;
        w_mc_start     = 1'b0;
        if (r_state == S_MC_WAIT && !i_mc_done) begin
            w_state_nxt   = S_MC_WAIT;
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_ex_hold     = 1'b1;
        end else if (i_ex_branch_taken && r_state != S_MC_WAIT) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (w_load_use) begin
            w_state_nxt    = S_LOAD_STALL;
            w_pc_stall     = 1'b1;
            w_if_id_stall  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (i_id_valid) begin
            w_issue = 1'b1;
            if (i_id_is_mc) begin
                w_mc_start  = 1'b1;
                w_state_nxt = S_MC_WAIT;
            end
        end
    end

    // Reset forces every control output low without waiting for a clock edge.
    assign o_pc_stall     = w_pc_stall     & ~i_rst;
    assign o_if_id_stall  = w_if_id_stall  & ~i_rst;
    assign o_if_id_flush  = w_if_id_flush  & ~i_rst;
    assign o_id_ex_bubble = w_id_ex_bubble & ~i_rst;
    assign o_ex_hold      = w_ex_hold      & ~i_rst;
    assign o_mc_start     = w_mc_start     & ~i_rst;
    assign o_fwd_rs1_sel  = r_fwd1;
    assign o_fwd_rs2_sel  = r_fwd2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RUN;
            r_ex    <= '0;
            r_mem   <= '0;
            r_fwd1  <= 2'b00;
            r_fwd2  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue)
                r_ex <= {1'b1, i_id_rd_wen, i_id_is_load, i_id_rd_addr};
            else if (!w_ex_hold)
                r_ex <= '0;
            r_mem  <= w_ex_hold ? '0 : {r_ex.valid, r_ex.wen, r_ex.rd};
            r_fwd1 <= w_issue ? w_fwd1 : 2'b00;
            r_fwd2 <= w_issue ? w_fwd2 : 2'b00;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (o_pc_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (o_if_id_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_perf_stall_cycles = r_stall_cnt;
    assign o_perf_flush_count  = r_flush_cnt;
`else
    assign o_perf_stall_cycles = '0;
    assign o_perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against an in-flight instruction model.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, rs1_used, rs2_used, rd_wen, is_load, is_mc, br, done;
    logic [4:0]  rs1, rs2, rd;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, mc_start;
    logic [1:0]  fwd1, fwd2;
    logic [31:0] perf_stall, perf_flush;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_id_rd_addr(rd), .i_id_rd_wen(rd_wen), .i_id_is_load(is_load), .i_id_is_mc(is_mc),
        .i_ex_branch_taken(br), .i_mc_done(done),
        .o_pc_stall(pc_stall), .o_if_id_stall(if_id_stall), .o_if_id_flush(if_id_flush),
        .o_id_ex_bubble(id_ex_bubble), .o_ex_hold(ex_hold), .o_mc_start(mc_start),
        .o_fwd_rs1_sel(fwd1), .o_fwd_rs2_sel(fwd2),
        .o_perf_stall_cycles(perf_stall), .o_perf_flush_count(perf_flush)
    );

    always #5 clk = ~clk;

    // Model: instructions occupying EX, MEM, WB (index 0..2), plus whether a multi-cycle op owns EX.
    typedef struct {
        bit v;
        bit wen;
        bit ld;
        int rd;
    } instr_t;

    instr_t m_pipe[3];
    bit     m_busy;
    int     m_f1, m_f2, m_stalls, m_flushes;
    bit     e_iss, e_hold, e_lu;
    int     e_f1, e_f2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input int rs, input bit used, input instr_t e);
        return used && e.v && e.wen && e.rd == rs && rs != 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_pipe[i] = '{0, 0, 0, 0};
        m_busy = 0; m_f1 = 0; m_f2 = 0; m_stalls = 0; m_flushes = 0;
    endtask

    // Drive ID/EX-side inputs at the falling edge, then compare everything before the next rising edge.
    task automatic apply(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                         input int d, input bit wen, input bit ld, input bit mc,
                         input bit b, input bit dn);
        bit h1e, h2e, h1m, h2m, brk;
        @(negedge clk);
        id_valid = v; rs1 = 5'(r1); rs1_used = u1; rs2 = 5'(r2); rs2_used = u2;
        rd = 5'(d); rd_wen = wen; is_load = ld; is_mc = mc; br = b; done = dn;
        #1;
        h1e = hit(r1, u1, m_pipe[0]); h2e = hit(r2, u2, m_pipe[0]);
        h1m = hit(r1, u1, m_pipe[1]); h2m = hit(r2, u2, m_pipe[1]);
        e_hold = m_busy && !dn;
        brk    = !m_busy && b;
        e_lu   = v && !e_hold && !brk && m_pipe[0].ld && (h1e || h2e);
        e_iss  = v && !e_hold && !brk && !e_lu;
        e_f1   = !e_iss ? 0 : (h1e ? 1 : (h1m ? 2 : 0));
        e_f2   = !e_iss ? 0 : (h2e ? 1 : (h2m ? 2 : 0));
        chk("pc_stall",     32'(pc_stall),     32'(e_hold || e_lu));
        chk("if_id_stall",  32'(if_id_stall),  32'(e_hold || e_lu));
        chk("if_id_flush",  32'(if_id_flush),  32'(brk));
        chk("id_ex_bubble", 32'(id_ex_bubble), 32'(brk || e_lu));
        chk("ex_hold",      32'(ex_hold),      32'(e_hold));
        chk("mc_start",     32'(mc_start),     32'(e_iss && mc));
        chk("fwd_rs1_sel",  32'(fwd1),         32'(m_f1));
        chk("fwd_rs2_sel",  32'(fwd2),         32'(m_f2));
`ifdef HAZARD_PERF_EN
        chk("perf_stall",   perf_stall,        32'(m_stalls));
        chk("perf_flush",   perf_flush,        32'(m_flushes));
`else
        chk("perf_stall",   perf_stall,        32'd0);
        chk("perf_flush",   perf_flush,        32'd0);
`endif
        if (e_hold || e_lu) m_stalls++;
        if (brk) m_flushes++;
    endtask

    task automatic tick();
        instr_t nx;
        @(posedge clk);
        nx = e_iss ? instr_t'{1, rd_wen, is_load, int'(rd)} : (e_hold ? m_pipe[0] : instr_t'{0, 0, 0, 0});
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = e_hold ? instr_t'{0, 0, 0, 0} : m_pipe[0];
        m_pipe[0] = nx;
        m_busy = (e_iss && is_mc) || e_hold;
        m_f1 = e_f1; m_f2 = e_f2;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    initial begin
        int stall_cnt;
        model_reset();
        rst = 1'b1;
        id_valid = 1; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; rd = 0; rd_wen = 0;
        is_load = 0; is_mc = 0; br = 1; done = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flush",  32'(if_id_flush),  32'd0);
        chk("rst_bubble", 32'(id_ex_bubble), 32'd0);
        chk("rst_fwd",    32'({fwd1, fwd2}), 32'd0);
        @(negedge clk); rst = 1'b0;

        // add x5,x1,x2 ; add x6,x5,x3 -> EX->EX forward on rs1
        apply(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0); tick();
        apply(1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 0);
        chk("dir_addadd_nostall", 32'(pc_stall), 32'd0); tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dir_fwd01", 32'(fwd1), 32'd1); tick();
        idle(); idle();

        // lw x5 ; add x6,x0,x5 -> one stall, then MEM forward on rs2
        apply(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0); tick();
        apply(1, 0, 1, 5, 1, 6, 1, 0, 0, 0, 0);
        chk("dir_lu_stall", 32'({pc_stall, if_id_stall, id_ex_bubble}), 32'b111); tick();
        apply(1, 0, 1, 5, 1, 6, 1, 0, 0, 0, 0);
        chk("dir_lu_once", 32'(pc_stall), 32'd0); tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dir_fwd10", 32'(fwd2), 32'd2); tick();
        idle(); idle();

        // add x0,x1,x2 ; add x6,x0,x0 -> x0 never matches
        apply(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0); tick();
        apply(1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0); tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("dir_x0_fwd", 32'({fwd1, fwd2}), 32'd0); tick();
        idle(); idle();

        // taken branch beats a pending load-use
        apply(1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0); tick();
        apply(1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 0);
        chk("dir_br_flush", 32'({if_id_flush, id_ex_bubble, pc_stall}), 32'b110); tick();
        idle(); idle();

        // multi-cycle op, 5 wait cycles, then done
        apply(1, 1, 1, 2, 1, 7, 1, 0, 1, 0, 0);
        chk("dir_mc_start", 32'(mc_start), 32'd1); tick();
        stall_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            apply(1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 0);
            if (pc_stall && ex_hold && !mc_start) stall_cnt++;
            tick();
        end
        chk("dir_mc_stall5", 32'(stall_cnt), 32'd5);
        apply(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 1);
        chk("dir_mc_done", 32'({pc_stall, ex_hold}), 32'd0); tick();
        idle(); idle();

        // async reset in the middle of MC_WAIT
        apply(1, 1, 1, 2, 1, 7, 1, 0, 1, 0, 0); tick();
        apply(1, 3, 1, 0, 0, 8, 1, 0, 0, 0, 0); // still waiting
        #2 rst = 1'b1;
        #1;
        chk("rst_async_outs", 32'({pc_stall, if_id_stall, ex_hold, mc_start, id_ex_bubble}), 32'd0);
        @(negedge clk); rst = 1'b0;
        model_reset();
        apply(1, 3, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        chk("rst_after_nostall", 32'(pc_stall), 32'd0); tick();

        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
